// File: rtl/tb_frame_checker.sv
// Readout frame checker: drains the readout FIFO, checks HEADER / K data / FOOTER framing, accumulates SEU statistics.
// Read at t, word valid t+1, state/stats/frame_done visible t+2; reads stop only on empty FIFO, en_i low or reset.
module tb_frame_checker #(
  parameter int unsigned  N      = 32,
  parameter int unsigned  K      = 576,
  parameter logic [N-1:0] HEADER = N'(32'h00AA_AAAA),
  parameter logic [N-1:0] FOOTER = N'(32'h00FF_FFFF)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_cnt_i,
  input  logic [N-1:0] exp_data_i,
  input  logic         fifo_empty_i,
  output logic         fifo_rd_o,
  input  logic [N-1:0] fifo_data_i,
  output logic         frame_done_o,
  output logic         in_frame_o,
  output logic [31:0]  frame_cnt_o,
  output logic [15:0]  hdr_skip_cnt_o,
  output logic [15:0]  ftr_err_cnt_o,
  output logic [31:0]  word_err_cnt_o,
  output logic [31:0]  bitflip_cnt_o
);

  localparam int unsigned PW       = $clog2(N + 1);
  localparam logic [15:0] LAST_IDX = 16'(K - 1);

  typedef enum logic [1:0] {HUNT, DATA, FTR} state_t;

  state_t        state_q, state_d;
  logic          vld_q, vld_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic [31:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]   hdr_skip_cnt_q, hdr_skip_cnt_d;
  logic [15:0]   ftr_err_cnt_q, ftr_err_cnt_d;
  logic [31:0]   word_err_cnt_q, word_err_cnt_d;
  logic [31:0]   bitflip_cnt_q, bitflip_cnt_d;
  logic          frame_done_q, frame_done_d;
  logic          in_frame_q, in_frame_d;
  logic [N-1:0]  diff;
  logic [PW-1:0] popcnt;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  // Reset gates the strobe so no word is popped that the FSM would then drop.
  assign fifo_rd_o = en_i & ~fifo_empty_i & ~rst_i;
  assign vld_d     = fifo_rd_o;

  always_comb begin
    diff   = fifo_data_i ^ exp_data_i;
    popcnt = '0;
    for (int i = 0; i < int'(N); i++) begin
      popcnt = popcnt + PW'(diff[i]);
    end
  end

  always_comb begin
    state_d        = state_q;
    wcnt_d         = wcnt_q;
    frame_cnt_d    = frame_cnt_q;
    hdr_skip_cnt_d = hdr_skip_cnt_q;
    ftr_err_cnt_d  = ftr_err_cnt_q;
    word_err_cnt_d = word_err_cnt_q;
    bitflip_cnt_d  = bitflip_cnt_q;
    frame_done_d   = 1'b0;
    if (vld_q) begin
      case (state_q)
        HUNT: begin
          if (fifo_data_i == HEADER) begin
            wcnt_d  = '0;
            state_d = DATA;
          end else begin
            hdr_skip_cnt_d = sat_inc16(hdr_skip_cnt_q);
          end
        end
        DATA: begin
          // Marker values are ordinary data here; framing is only re-checked at the footer slot.
          bitflip_cnt_d = sat_add32(bitflip_cnt_q, 32'(popcnt));
          if (diff != '0) word_err_cnt_d = sat_add32(word_err_cnt_q, 32'd1);
          wcnt_d = wcnt_q + 16'd1;
          if (wcnt_q == LAST_IDX) state_d = FTR;
        end
        FTR: begin
          if (fifo_data_i == FOOTER) begin
            frame_cnt_d  = sat_add32(frame_cnt_q, 32'd1);
            frame_done_d = 1'b1;
            state_d      = HUNT;
          end else if (fifo_data_i == HEADER) begin
            ftr_err_cnt_d = sat_inc16(ftr_err_cnt_q);
            wcnt_d        = '0;
            state_d       = DATA;
          end else begin
            ftr_err_cnt_d = sat_inc16(ftr_err_cnt_q);
            state_d       = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    // Clear beats any same-cycle increment; the FSM keeps running.
    if (clr_cnt_i) begin
      frame_cnt_d    = '0;
      hdr_skip_cnt_d = '0;
      ftr_err_cnt_d  = '0;
      word_err_cnt_d = '0;
      bitflip_cnt_d  = '0;
    end
    in_frame_d = (state_d == DATA) || (state_d == FTR);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= HUNT;
      vld_q          <= 1'b0;
      wcnt_q         <= '0;
      frame_cnt_q    <= '0;
      hdr_skip_cnt_q <= '0;
      ftr_err_cnt_q  <= '0;
      word_err_cnt_q <= '0;
      bitflip_cnt_q  <= '0;
      frame_done_q   <= 1'b0;
      in_frame_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      vld_q          <= vld_d;
      wcnt_q         <= wcnt_d;
      frame_cnt_q    <= frame_cnt_d;
      hdr_skip_cnt_q <= hdr_skip_cnt_d;
      ftr_err_cnt_q  <= ftr_err_cnt_d;
      word_err_cnt_q <= word_err_cnt_d;
      bitflip_cnt_q  <= bitflip_cnt_d;
      frame_done_q   <= frame_done_d;
      in_frame_q     <= in_frame_d;
    end
  end

  assign frame_done_o   = frame_done_q;
  assign in_frame_o     = in_frame_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign hdr_skip_cnt_o = hdr_skip_cnt_q;
  assign ftr_err_cnt_o  = ftr_err_cnt_q;
  assign word_err_cnt_o = word_err_cnt_q;
  assign bitflip_cnt_o  = bitflip_cnt_q;

endmodule

// File: tb/tb_tb_frame_checker.sv
// Bench for tb_frame_checker with K=4: queue-backed FIFO model, frame_done scoreboard, one task per scenario.
module tb_tb_frame_checker;
  localparam logic [31:0] HDR = 32'h00AA_AAAA;
  localparam logic [31:0] FTR = 32'h00FF_FFFF;
  localparam logic [31:0] EXP = 32'h5555_5555;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, en_i = 1'b0, clr_cnt_i = 1'b0;
  logic [31:0] exp_data_i = EXP;
  logic [31:0] fifo_data_i = '0;
  logic        fifo_empty_i, fifo_rd_o, frame_done_o, in_frame_o;
  logic [31:0] frame_cnt_o, word_err_cnt_o, bitflip_cnt_o;
  logic [15:0] hdr_skip_cnt_o, ftr_err_cnt_o;

  int          n_checks = 0, n_fail = 0;
  int          n_push = 0, n_pop = 0, cyc_n = 0, m_frames = 0;
  logic [31:0] fq[$];
  logic [31:0] exp_q[$];
  int          obs_t[$];

  tb_frame_checker #(.N(32), .K(4), .HEADER(HDR), .FOOTER(FTR)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clr_cnt_i(clr_cnt_i), .exp_data_i(exp_data_i),
    .fifo_empty_i(fifo_empty_i), .fifo_rd_o(fifo_rd_o), .fifo_data_i(fifo_data_i),
    .frame_done_o(frame_done_o), .in_frame_o(in_frame_o), .frame_cnt_o(frame_cnt_o),
    .hdr_skip_cnt_o(hdr_skip_cnt_o), .ftr_err_cnt_o(ftr_err_cnt_o),
    .word_err_cnt_o(word_err_cnt_o), .bitflip_cnt_o(bitflip_cnt_o)
  );

  always #5 clk = ~clk;

  // Read-latency-1 FIFO model.
  assign fifo_empty_i = (n_push == n_pop);
  always @(posedge clk) begin
    if (fifo_rd_o) begin
      fifo_data_i <= fq.pop_front();
      n_pop       <= n_pop + 1;
    end
  end

  // One clock step; every frame_done pulse is matched against the scoreboard here.
  task automatic cyc();
    logic [31:0] e;
    @(negedge clk);
    cyc_n++;
    if (frame_done_o === 1'b1) begin
      obs_t.push_back(cyc_n);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL sb_unexpected_done: frame_cnt %0d, no frame expected", frame_cnt_o);
      end else begin
        e = exp_q.pop_front();
        if (frame_cnt_o !== e) begin
          n_fail++; $display("FAIL sb_frame_cnt: got %0d want %0d", frame_cnt_o, e);
        end
      end
    end
  endtask

  task automatic push_w(input logic [31:0] w);
    fq.push_back(w);
    n_push++;
  endtask

  task automatic push_frame(input logic [31:0] d0, d1, d2, d3, ftr);
    push_w(HDR); push_w(d0); push_w(d1); push_w(d2); push_w(d3); push_w(ftr);
    if (ftr == FTR) begin
      m_frames++;
      exp_q.push_back(32'(m_frames));
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && n_push != n_pop; i++) cyc();
    repeat (4) cyc();
    n_checks++;
    if (n_push != n_pop) begin
      n_fail++; $display("FAIL drain_timeout: %0d words left want 0", n_push - n_pop);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; en_i = 1'b0; clr_cnt_i = 1'b0;
    cyc(); cyc();
    rst_i = 1'b0;
    exp_q.delete(); obs_t.delete(); m_frames = 0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; en_i = 1'b1;
    push_w(32'hDEAD_BEEF);
    cyc(); cyc();
    n_checks++; if (fifo_rd_o !== 1'b0) begin n_fail++; $display("FAIL rst_rd: got %b want 0", fifo_rd_o); end
    n_checks++; if ({in_frame_o, frame_done_o} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b want 00", {in_frame_o, frame_done_o}); end
    n_checks++;
    if ({frame_cnt_o, word_err_cnt_o, bitflip_cnt_o, hdr_skip_cnt_o, ftr_err_cnt_o} !== 128'd0) begin
      n_fail++; $display("FAIL rst_counters: got %0d %0d %0d %0d %0d want all 0", frame_cnt_o, word_err_cnt_o, bitflip_cnt_o, hdr_skip_cnt_o, ftr_err_cnt_o);
    end
    rst_i = 1'b0;
    wait_idle();
    n_checks++; if (hdr_skip_cnt_o !== 16'd1) begin n_fail++; $display("FAIL rst_then_skip: got %0d want 1", hdr_skip_cnt_o); end
    n_checks++; if (fifo_rd_o !== 1'b0) begin n_fail++; $display("FAIL rst_rd_empty: got %b want 0", fifo_rd_o); end
  endtask

  task automatic test_clean();
    int t0;
    do_reset(); en_i = 1'b1;
    t0 = cyc_n;
    push_frame(EXP, EXP, EXP, EXP, FTR);
    wait_idle();
    n_checks++; if (frame_cnt_o !== 32'd1) begin n_fail++; $display("FAIL clean_frames: got %0d want 1", frame_cnt_o); end
    n_checks++;
    if ({word_err_cnt_o, bitflip_cnt_o, hdr_skip_cnt_o, ftr_err_cnt_o} !== 96'd0) begin
      n_fail++; $display("FAIL clean_errs: got %0d %0d %0d %0d want 0", word_err_cnt_o, bitflip_cnt_o, hdr_skip_cnt_o, ftr_err_cnt_o);
    end
    n_checks++; if ({fifo_rd_o, in_frame_o} !== 2'b00) begin n_fail++; $display("FAIL clean_idle: got %b want 00", {fifo_rd_o, in_frame_o}); end
    n_checks++;
    if (obs_t.size() != 1 || obs_t[0] - t0 != 7) begin
      n_fail++; $display("FAIL clean_latency: got %0d pulses, first at +%0d, want 1 at +7", obs_t.size(), (obs_t.size() > 0) ? obs_t[0] - t0 : -1);
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL clean_missing_done: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_bitflip();
    do_reset(); en_i = 1'b1;
    push_frame(32'h5555_5554, 32'h5555_5555, 32'hD555_5555, 32'h5555_0000, FTR);
    wait_idle();
    n_checks++; if (word_err_cnt_o !== 32'd3) begin n_fail++; $display("FAIL flip_words: got %0d want 3", word_err_cnt_o); end
    n_checks++; if (bitflip_cnt_o !== 32'd10) begin n_fail++; $display("FAIL flip_bits: got %0d want 10", bitflip_cnt_o); end
    n_checks++; if (frame_cnt_o !== 32'd1) begin n_fail++; $display("FAIL flip_frames: got %0d want 1", frame_cnt_o); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL flip_missing_done: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_garbage();
    do_reset(); en_i = 1'b1;
    push_w(32'h1234_5678); push_w(32'h0);
    push_frame(EXP, EXP, EXP, EXP, FTR);
    wait_idle();
    n_checks++; if (hdr_skip_cnt_o !== 16'd2) begin n_fail++; $display("FAIL garbage_skip: got %0d want 2", hdr_skip_cnt_o); end
    n_checks++; if (frame_cnt_o !== 32'd1) begin n_fail++; $display("FAIL garbage_frames: got %0d want 1", frame_cnt_o); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL garbage_missing_done: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_bad_footer();
    do_reset(); en_i = 1'b1;
    push_frame(EXP, EXP, EXP, EXP, 32'h00FF_FFFE);
    push_frame(EXP, EXP, EXP, EXP, FTR);
    wait_idle();
    n_checks++; if (ftr_err_cnt_o !== 16'd1) begin n_fail++; $display("FAIL badftr_err: got %0d want 1", ftr_err_cnt_o); end
    n_checks++; if (frame_cnt_o !== 32'd1) begin n_fail++; $display("FAIL badftr_frames: got %0d want 1", frame_cnt_o); end
    n_checks++; if (hdr_skip_cnt_o !== 16'd0) begin n_fail++; $display("FAIL badftr_skip: got %0d want 0", hdr_skip_cnt_o); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL badftr_missing_done: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_hdr_in_footer();
    do_reset(); en_i = 1'b1;
    push_w(HDR); push_w(EXP); push_w(EXP); push_w(EXP); push_w(EXP);
    push_frame(EXP, EXP, EXP, EXP, FTR);
    wait_idle();
    n_checks++; if (ftr_err_cnt_o !== 16'd1) begin n_fail++; $display("FAIL resync_err: got %0d want 1", ftr_err_cnt_o); end
    n_checks++; if (frame_cnt_o !== 32'd1) begin n_fail++; $display("FAIL resync_frames: got %0d want 1", frame_cnt_o); end
    n_checks++; if (hdr_skip_cnt_o !== 16'd0) begin n_fail++; $display("FAIL resync_skip: got %0d want 0", hdr_skip_cnt_o); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL resync_missing_done: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset(); en_i = 1'b1;
    push_frame(EXP, EXP, EXP, EXP, FTR);
    push_frame(EXP, EXP, EXP, EXP, FTR);
    wait_idle();
    n_checks++; if (frame_cnt_o !== 32'd2) begin n_fail++; $display("FAIL b2b_frames: got %0d want 2", frame_cnt_o); end
    n_checks++;
    if (obs_t.size() != 2 || obs_t[1] - obs_t[0] != 6) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d pulses, gap %0d, want 2 pulses gap 6", obs_t.size(), (obs_t.size() == 2) ? obs_t[1] - obs_t[0] : -1);
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing_done: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_clear();
    do_reset(); en_i = 1'b1;
    push_w(HDR); push_w(32'h5555_5554);
    cyc(); cyc();
    clr_cnt_i = 1'b1;  // erroring word is valid in this cycle
    cyc();
    clr_cnt_i = 1'b0;
    n_checks++;
    if ({word_err_cnt_o, bitflip_cnt_o} !== 64'd0) begin
      n_fail++; $display("FAIL clr_wins: got werr %0d bits %0d want 0 0", word_err_cnt_o, bitflip_cnt_o);
    end
    n_checks++; if (in_frame_o !== 1'b1) begin n_fail++; $display("FAIL clr_fsm_kept: got in_frame %b want 1", in_frame_o); end
    push_w(32'h5555_5554); push_w(EXP); push_w(EXP); push_w(FTR);
    m_frames++; exp_q.push_back(32'(m_frames));
    wait_idle();
    n_checks++; if (word_err_cnt_o !== 32'd1) begin n_fail++; $display("FAIL clr_after_werr: got %0d want 1", word_err_cnt_o); end
    n_checks++; if (bitflip_cnt_o !== 32'd1) begin n_fail++; $display("FAIL clr_after_bits: got %0d want 1", bitflip_cnt_o); end
    n_checks++; if (frame_cnt_o !== 32'd1) begin n_fail++; $display("FAIL clr_after_frames: got %0d want 1", frame_cnt_o); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL clr_missing_done: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset(); en_i = 1'b1;
    push_w(32'h1); push_w(HDR); push_w(32'h5555_5554); push_w(EXP);
    wait_idle();
    n_checks++;
    if ({in_frame_o, word_err_cnt_o, hdr_skip_cnt_o} !== {1'b1, 32'd1, 16'd1}) begin
      n_fail++; $display("FAIL midrst_pre: got in_frame %b werr %0d skip %0d want 1 1 1", in_frame_o, word_err_cnt_o, hdr_skip_cnt_o);
    end
    do_reset();
    n_checks++; if (in_frame_o !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got in_frame %b want 0", in_frame_o); end
    n_checks++;
    if ({frame_cnt_o, word_err_cnt_o, bitflip_cnt_o, hdr_skip_cnt_o, ftr_err_cnt_o} !== 128'd0) begin
      n_fail++; $display("FAIL midrst_counters: got %0d %0d %0d %0d %0d want all 0", frame_cnt_o, word_err_cnt_o, bitflip_cnt_o, hdr_skip_cnt_o, ftr_err_cnt_o);
    end
    en_i = 1'b1;
    push_frame(EXP, EXP, EXP, EXP, FTR);
    wait_idle();
    n_checks++;
    if ({frame_cnt_o, hdr_skip_cnt_o, ftr_err_cnt_o, word_err_cnt_o} !== {32'd1, 16'd0, 16'd0, 32'd0}) begin
      n_fail++; $display("FAIL midrst_next_frame: got frames %0d skip %0d ftr %0d werr %0d want 1 0 0 0", frame_cnt_o, hdr_skip_cnt_o, ftr_err_cnt_o, word_err_cnt_o);
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_missing_done: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_enable_gap();
    logic rd_seen;
    do_reset(); en_i = 1'b1;
    push_frame(EXP, EXP, EXP, EXP, FTR);
    cyc(); cyc();
    en_i = 1'b0;
    rd_seen = 1'b0;
    repeat (5) begin cyc(); rd_seen = rd_seen | fifo_rd_o; end
    n_checks++; if (rd_seen !== 1'b0) begin n_fail++; $display("FAIL engap_rd: got read while disabled want none"); end
    n_checks++;
    if ({in_frame_o, frame_cnt_o} !== {1'b1, 32'd0}) begin
      n_fail++; $display("FAIL engap_hold: got in_frame %b frames %0d want 1 0", in_frame_o, frame_cnt_o);
    end
    en_i = 1'b1;
    wait_idle();
    n_checks++; if (frame_cnt_o !== 32'd1) begin n_fail++; $display("FAIL engap_frames: got %0d want 1", frame_cnt_o); end
    n_checks++; if (word_err_cnt_o !== 32'd0) begin n_fail++; $display("FAIL engap_werr: got %0d want 0", word_err_cnt_o); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL engap_missing_done: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_saturate();
    do_reset();
    // Preload the counter during an idle cycle so the held value matches its next-state.
    force dut.bitflip_cnt_q = 32'hFFFF_FFF0;
    cyc();
    release dut.bitflip_cnt_q;
    en_i = 1'b1;
    push_w(HDR); push_w(32'hAAAA_AAAA); push_w(32'hAAAA_AAAA);
    wait_idle();
    n_checks++; if (bitflip_cnt_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_bits: got %h want ffffffff", bitflip_cnt_o); end
    n_checks++; if (word_err_cnt_o !== 32'd2) begin n_fail++; $display("FAIL sat_werr: got %0d want 2", word_err_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bitflip();
    test_garbage();
    test_bad_footer();
    test_hdr_in_footer();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_enable_gap();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
